ram_loader: RTL
===============

# ram_loader

Serial boot loader that sits directly upstream of the 64 KB system RAM. It consumes a byte stream from the UART receiver, decodes a framed load command, and writes the payload into RAM through the RAM's single write port. While loading, it holds the Z80 in reset so that the CPU never sees a half-written image. On a successful frame it reports completion and releases the CPU.

## Interface
Parameters:
- TIMEOUT, 24'd2_500_000: idle clock cycles allowed between bytes inside a frame before abort (100 ms at 25 MHz).
- BOOT_HOLD, 1: when 1, cpu_hold is asserted from reset until the first good frame completes. When 0, cpu_hold is asserted only during a frame.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- rx_valid, input, 1: one-cycle strobe marking that rx_data holds a received byte.
- rx_data, input, 8: received byte.
- ram_we, output, 1: RAM write enable.
- ram_addr, output, 16: RAM address.
- ram_din, output, 8: RAM write data.
- cpu_hold, output, 1: high holds the CPU in reset and gives the RAM port mux to this block.
- done, output, 1: one-cycle pulse when a frame completes with a good checksum.
- error, output, 1: sticky flag for a checksum mismatch or timeout. It is cleared at the next sync byte.

## Operation
- The frame format is: 0x55 sync, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CSUM.
- CSUM is the 8-bit sum of the data bytes only.
- States and transitions:
  - IDLE: a byte of 0x55 goes to ADDR_H. All other bytes are ignored.
  - ADDR_H and ADDR_L load a 16-bit address register.
  - LEN_H and LEN_L load a 16-bit remaining-count register.
  - After LEN_L: if LEN is 0, go to CSUM; otherwise go to DATA.
  - DATA, on each byte:
    - issue a write to the current address;
    - add the byte to an 8-bit running sum, modulo 256;
    - increment the address modulo 2^16, so 0xFFFF wraps to 0x0000;
    - decrement the count;
    - when the count reaches 0, go to CSUM.
  - CSUM: compare rx_data with the running sum. On a match, pulse done; on a mismatch, set error. Either way, return to IDLE.
- Written bytes are not rolled back on a checksum error.
- Sync byte:
  - The running sum is cleared.
  - error is cleared.
  - cpu_hold is asserted.
- cpu_hold:
  - With BOOT_HOLD=0, cpu_hold falls when the frame ends, whether it ended good, with a bad checksum, or by timeout.
  - With BOOT_HOLD=1, cpu_hold stays high after reset and after failed frames. It falls only after the first good frame. From then on it behaves as with BOOT_HOLD=0.
- Timeout:
  - In any state other than IDLE, an idle counter increments every cycle without rx_valid. The counter resets to 0 on each rx_valid.
  - When the counter reaches TIMEOUT: set error, go to IDLE, and apply the cpu_hold rule above.
  - A rx_valid arriving in the same cycle as the timeout wins: the byte is processed and the counter clears.
- A 0x55 byte received outside IDLE is treated as data or header, never as a resync.

## Timing
- Reset values:
  - ram_we = 0, ram_addr = 0, ram_din = 0, done = 0, error = 0.
  - cpu_hold = BOOT_HOLD.
  - State = IDLE, idle counter = 0.
- All outputs are registered.
- Write latency: a data byte sampled at edge N gives ram_we = 1 for exactly one cycle after edge N. During that cycle, ram_addr and ram_din are stable with that byte's address and data, and the RAM captures the write at edge N+1.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss. There is no backpressure.
- done pulses for one cycle after the edge that samples CSUM. cpu_hold falls on the same cycle.
- When ram_we is low, ram_addr holds its last value.

## Test plan
- Reset with BOOT_HOLD=1 -> cpu_hold=1, all other outputs 0. With no rx activity the state stays IDLE and no timeout fires.
- Stream 55 12 34 00 03 AA BB CC 31 (sum 0x231 mod 256 = 0x31) -> three one-cycle writes 0x1234=AA, 0x1235=BB, 0x1236=CC; then done=1 for one cycle, cpu_hold falls, error=0.
- Stream 55 FF FE 00 04 01 02 03 04 0A -> writes go to FFFE, FFFF, 0000, 0001 (wrap-around); done pulses.
- Stream 55 00 00 00 01 7F 00 (bad CSUM) -> write 0x0000=7F, error=1, no done; with BOOT_HOLD=1, cpu_hold stays 1. Then a good frame -> error clears at the sync byte, done pulses, cpu_hold falls.
- Stream 55 00 10 then silence for TIMEOUT cycles -> error=1, state returns to IDLE, and the next 55 starts a fresh frame. LEN=0 frame 55 00 00 00 00 00 -> no writes, done pulses.
- Assert resetn low during the DATA state -> outputs return to reset values immediately (asynchronous). The partial frame is abandoned and the following frame loads correctly.

Source files
------------

// File: rtl/ram_loader.sv
// Serial boot loader: decodes framed load commands from a UART byte stream,
// writes the payload into system RAM and holds the CPU in reset while loading.
module ram_loader #(
    parameter logic [23:0] TIMEOUT   = 24'd2_500_000,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    // rx_valid is a one-cycle strobe qualifying rx_data; there is no ready,
    // so every strobed byte is consumed in the cycle it is presented.
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_H = 3'd1,
        S_ADDR_L = 3'd2,
        S_LEN_H  = 3'd3,
        S_LEN_L  = 3'd4,
        S_DATA   = 3'd5,
        S_CSUM   = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [23:0] idle_q, idle_d;
    logic        we_q, we_d;
    logic [15:0] waddr_q, waddr_d;
    logic [7:0]  din_q, din_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        hold_q, hold_d;
    logic        booted_q, booted_d;

    logic [15:0] frame_len;
    logic        fail_hold;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= 16'h0000;
            cnt_q    <= 16'h0000;
            sum_q    <= 8'h00;
            idle_q   <= 24'd0;
            we_q     <= 1'b0;
            waddr_q  <= 16'h0000;
            din_q    <= 8'h00;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= BOOT_HOLD;
            booted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            idle_q   <= idle_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            din_q    <= din_d;
            done_q   <= done_d;
            error_q  <= error_d;
            hold_q   <= hold_d;
            booted_q <= booted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        idle_d    = idle_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        din_d     = din_q;
        done_d    = 1'b0;
        error_d   = error_q;
        hold_d    = hold_q;
        booted_d  = booted_q;
        frame_len = {cnt_q[15:8], rx_data};
        // Until the first good image lands, a failed frame keeps the CPU parked.
        fail_hold = BOOT_HOLD && !booted_q;

        if (state_q == S_IDLE) begin
            idle_d = 24'd0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
                state_d = S_ADDR_H;
                sum_d   = 8'h00;
                error_d = 1'b0;
                hold_d  = 1'b1;
            end
        end else if (rx_valid) begin
            // A byte arriving on the timeout cycle takes priority over the abort.
            idle_d = 24'd0;
            case (state_q)
                S_ADDR_H: begin
                    addr_d  = {rx_data, addr_q[7:0]};
                    state_d = S_ADDR_L;
                end
                S_ADDR_L: begin
                    addr_d  = {addr_q[15:8], rx_data};
                    state_d = S_LEN_H;
                end
                S_LEN_H: begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    cnt_d   = frame_len;
                    state_d = (frame_len == 16'h0000) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    din_d   = rx_data;
                    addr_d  = addr_q + 16'd1;
                    sum_d   = sum_q + rx_data;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (rx_data == sum_q) begin
                        done_d   = 1'b1;
                        booted_d = 1'b1;
                        hold_d   = 1'b0;
                    end else begin
                        error_d = 1'b1;
                        hold_d  = fail_hold;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (idle_q == TIMEOUT) begin
            state_d = S_IDLE;
            idle_d  = 24'd0;
            error_d = 1'b1;
            hold_d  = fail_hold;
        end else begin
            idle_d = idle_q + 24'd1;
        end
    end

    assign ram_we   = we_q;
    assign ram_addr = waddr_q;
    assign ram_din  = din_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cpu_hold = hold_q;
    assign state_o  = state_q;

endmodule
